// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs fields into 32-bit words, buffers them, writes to memory.
// Optional ILLEGAL_ENCODING_CHECK_EN drops words outside the legal opcode/func set.
module instr_encode_loader #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              end_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_opcode,
  input  logic [3:0]        in_func,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              busy,
  output logic              wrap_err,
  output logic              illegal,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              wrap_q, wrap_d;

  logic        active, full, empty;
  logic        xfer, enq, deq, sess_go;
  logic [31:0] enc;

  assign active  = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign sess_go = (state_q == S_IDLE) && start;

  assign in_ready = (state_q == S_LOAD) && !full;
  assign xfer     = in_valid && in_ready;
  assign enc      = {in_opcode, in_rs, in_rt, in_imm, in_func};

  assign mem_we    = active && !empty;
  assign deq       = mem_we && mem_ready;
  assign mem_wdata = fifo_q[rd_q];
  assign mem_addr  = addr_q;
  assign word_cnt  = wcnt_q;
  assign wrap_err  = wrap_q;
  assign done      = (state_q == S_DONE);
  assign busy      = active;

`ifdef ILLEGAL_ENCODING_CHECK_EN
  logic legal;
  logic ill_q;

  always_comb begin
    legal = 1'b0;
    unique case (in_opcode)
      2'd0:    legal = (in_func != 4'd8) && (in_func != 4'd9);
      2'd3:    legal = (in_func <= 4'd7) ||
                       ((in_func >= 4'd9) && (in_func <= 4'd12));
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else if (sess_go) begin
      ill_q <= 1'b0;
    end else if (xfer && !legal) begin
      ill_q <= 1'b1;
    end
  end

  assign enq     = xfer && legal;
  assign illegal = ill_q;
`else
  assign enq     = xfer;
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = base_addr;
          wcnt_d  = '0;
          wrap_d  = 1'b0;
        end
      end
      S_LOAD:  if (end_req) state_d = S_FLUSH;
      S_FLUSH: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // deq only happens in LOAD/FLUSH, so it never races the start load
    if (deq) begin
      addr_d = addr_q + ADDR_W'(1);
      wcnt_d = wcnt_q + (ADDR_W+1)'(1);
      if (&addr_q) wrap_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      if (enq) wr_q <= wr_q + PW'(1);
      if (deq) rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_q] <= enc;
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader.
// One task per scenario; writes and done pulses are logged by a negedge monitor.
module tb_instr_encode_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          end_req = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_opcode = '0;
  logic [3:0]    in_func = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [15:0]   in_imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b1;
  logic          done;
  logic          busy;
  logic          wrap_err;
  logic          illegal;
  logic [AW:0]   word_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  int            wc [$];

  instr_encode_loader #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .end_req(end_req), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func), .in_rs(in_rs),
    .in_rt(in_rt), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .done(done), .busy(busy), .wrap_err(wrap_err), .illegal(illegal),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we && mem_ready && !rst) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] enc(input logic [1:0] op,
                                      input logic [3:0] fn,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm, fn};
  endfunction

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
  endtask

  task automatic start_session(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_session();
    end_req = 1'b1;
    @(posedge clk); #1;
    end_req = 1'b0;
  endtask

  task automatic push_word(input logic [1:0] op, input logic [3:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input bit with_end);
    bit ok;
    ok = 1'b0;
    in_opcode = op;
    in_func = fn;
    in_rs = rs;
    in_rt = rt;
    in_imm = imm;
    in_valid = 1'b1;
    end_req = with_end;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout in_ready stayed 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    end_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout done=0 required 1");
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, in_ready, done, busy, wrap_err, illegal} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {mem_we, in_ready, done, busy, wrap_err, illegal});
    end
    checks++;
    if (word_cnt !== '0) begin
      failures++;
      $display("FAIL reset_word_cnt got=%0d required=0", word_cnt);
    end
    checks++;
    if (mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_mem_addr got=%h required=0", mem_addr);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore in_ready=%b mem_we=%b required 0 0",
               in_ready, mem_we);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea [3];
    logic [31:0]   ed [3];
    ea = '{10'h010, 10'h011, 10'h012};
    ed = '{32'h02200030, 32'h06400100, 32'h3FFFFFF0};
    clear_log();
    mem_ready = 1'b1;
    start_session(10'h010);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b required=1", busy);
    end
    push_word(2'd0, 4'd0, 5'd1, 5'd2, 16'h0003, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h02200030) begin
      failures++;
      $display("FAIL basic_latency we=%b data=%h required 1 02200030",
               mem_we, mem_wdata);
    end
    push_word(2'd0, 4'd0, 5'd3, 5'd4, 16'h0010, 1'b0);
    push_word(2'd0, 4'd0, 5'd31, 5'd31, 16'hFFFF, 1'b0);
    end_session();
    wait_done();
    checks++;
    if (wa.size() !== 3) begin
      failures++;
      $display("FAIL basic_nwrites got=%0d required=3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          failures++;
          $display("FAIL basic_write%0d got=%h/%h required=%h/%h",
                   i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (word_cnt !== 11'd3 || done_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end cnt=%0d dones=%0d busy=%b required 3 1 0",
               word_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int stall_bad;
    bit taken;
    acc = 0;
    stall_bad = 0;
    clear_log();
    mem_ready = 1'b0;
    start_session(10'h100);
    for (int c = 0; c < 10; c++) begin
      in_opcode = 2'd0;
      in_func = 4'(acc);
      in_rs = 5'(acc);
      in_rt = 5'(acc + 1);
      in_imm = 16'(16'hA000 + acc);
      in_valid = 1'b1;
      @(negedge clk);
      taken = in_ready;
      if (c >= 1 && (mem_wdata !== enc(2'd0, 4'd0, 5'd0, 5'd1, 16'hA000) ||
                     mem_addr !== 10'h100 || mem_we !== 1'b1))
        stall_bad++;
      @(posedge clk); #1;
      if (taken) acc++;
    end
    checks++;
    if (acc !== 4) begin
      failures++;
      $display("FAIL bp_accepted got=%0d required=4", acc);
    end
    checks++;
    if (stall_bad !== 0) begin
      failures++;
      $display("FAIL bp_stable unstable_cycles=%0d required=0", stall_bad);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_deq in_ready=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    push_word(2'd0, 4'd4, 5'd4, 5'd5, 16'hA004, 1'b0);
    push_word(2'd0, 4'd5, 5'd5, 5'd6, 16'hA005, 1'b0);
    end_session();
    wait_done();
    checks++;
    if (wa.size() !== 6) begin
      failures++;
      $display("FAIL bp_nwrites got=%0d required=6", wa.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wa[i] !== AW'(10'h100 + i) ||
            wd[i] !== enc(2'd0, 4'(i), 5'(i), 5'(i + 1), 16'(16'hA000 + i))) begin
          failures++;
          $display("FAIL bp_write%0d got=%h/%h required=%h/%h", i, wa[i], wd[i],
                   AW'(10'h100 + i),
                   enc(2'd0, 4'(i), 5'(i), 5'(i + 1), 16'(16'hA000 + i)));
        end
      end
    end
    checks++;
    if (word_cnt !== 11'd6) begin
      failures++;
      $display("FAIL bp_word_cnt got=%0d required=6", word_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [3];
    ea = '{10'h3FE, 10'h3FF, 10'h000};
    clear_log();
    mem_ready = 1'b1;
    start_session(10'h3FE);
    push_word(2'd3, 4'd5, 5'd0, 5'd0, 16'h1234, 1'b0);
    checks++;
    if (mem_wdata !== 32'hC0012345) begin
      failures++;
      $display("FAIL wrap_encode got=%h required=C0012345", mem_wdata);
    end
    push_word(2'd0, 4'd1, 5'd2, 5'd3, 16'h0001, 1'b0);
    push_word(2'd0, 4'd2, 5'd4, 5'd5, 16'h0002, 1'b0);
    end_session();
    wait_done();
    checks++;
    if (wa.size() !== 3) begin
      failures++;
      $display("FAIL wrap_nwrites got=%0d required=3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== ea[i]) begin
          failures++;
          $display("FAIL wrap_addr%0d got=%h required=%h", i, wa[i], ea[i]);
        end
      end
    end
    checks++;
    if (wrap_err !== 1'b1 || word_cnt !== 11'd3) begin
      failures++;
      $display("FAIL wrap_flag wrap_err=%b cnt=%0d required 1 3",
               wrap_err, word_cnt);
    end
  endtask

  task automatic test_illegal();
    int          exp_n;
    logic        exp_ill;
    logic [31:0] w0, w1, w2;
    w0 = enc(2'd0, 4'd1, 5'd1, 5'd1, 16'h0101);
    w1 = enc(2'd3, 4'd8, 5'd2, 5'd2, 16'h0202);
    w2 = enc(2'd3, 4'd9, 5'd3, 5'd3, 16'h0303);
`ifdef ILLEGAL_ENCODING_CHECK_EN
    exp_n = 2;
    exp_ill = 1'b1;
`else
    exp_n = 3;
    exp_ill = 1'b0;
`endif
    clear_log();
    mem_ready = 1'b1;
    start_session(10'h020);
    checks++;
    if (wrap_err !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_wrap got=%b required=0", wrap_err);
    end
    push_word(2'd0, 4'd1, 5'd1, 5'd1, 16'h0101, 1'b0);
    push_word(2'd3, 4'd8, 5'd2, 5'd2, 16'h0202, 1'b0);
    push_word(2'd3, 4'd9, 5'd3, 5'd3, 16'h0303, 1'b0);
    end_session();
    wait_done();
    checks++;
    if (wa.size() !== exp_n || word_cnt !== 11'(exp_n)) begin
      failures++;
      $display("FAIL ill_count writes=%0d cnt=%0d required=%0d",
               wa.size(), word_cnt, exp_n);
    end else begin
      checks++;
      if (wd[0] !== w0 || wd[exp_n-1] !== w2 ||
          (exp_n == 3 && wd[1] !== w1)) begin
        failures++;
        $display("FAIL ill_data first=%h last=%h required=%h %h",
                 wd[0], wd[exp_n-1], w0, w2);
      end
    end
    checks++;
    if (illegal !== exp_ill) begin
      failures++;
      $display("FAIL ill_flag got=%b required=%b", illegal, exp_ill);
    end
  endtask

  task automatic test_rst_flush();
    clear_log();
    mem_ready = 1'b0;
    start_session(10'h040);
    push_word(2'd0, 4'd1, 5'd1, 5'd2, 16'h0011, 1'b0);
    push_word(2'd0, 4'd2, 5'd3, 5'd4, 16'h0022, 1'b0);
    push_word(2'd0, 4'd3, 5'd5, 5'd6, 16'h0033, 1'b0);
    end_session();
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_state busy=%b we=%b rdy=%b required 1 1 0",
               busy, mem_we, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || word_cnt !== '0 ||
        mem_addr !== '0) begin
      failures++;
      $display("FAIL rst_flush busy=%b we=%b cnt=%0d addr=%h required 0 0 0 0",
               busy, mem_we, word_cnt, mem_addr);
    end
    mem_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (wa.size() !== 0 || done_cnt !== 0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_writes writes=%0d dones=%0d we=%b required 0 0 0",
               wa.size(), done_cnt, mem_we);
    end
  endtask

  task automatic test_back_to_back_end();
    logic [31:0] w1;
    w1 = enc(2'd3, 4'd12, 5'd7, 5'd8, 16'hBEEF);
    clear_log();
    mem_ready = 1'b1;
    start_session(10'h050);
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_ill got=%b required=0", illegal);
    end
    push_word(2'd0, 4'd10, 5'd9, 5'd9, 16'h1111, 1'b0);
    push_word(2'd3, 4'd12, 5'd7, 5'd8, 16'hBEEF, 1'b1);
    wait_done();
    checks++;
    if (wa.size() !== 2) begin
      failures++;
      $display("FAIL coinc_nwrites got=%0d required=2", wa.size());
    end else begin
      checks++;
      if (wd[1] !== w1 || wa[1] !== 10'h051 || wc[1] >= done_cyc) begin
        failures++;
        $display("FAIL coinc_last data=%h addr=%h wcyc=%0d dcyc=%0d required %h 051 before",
                 wd[1], wa[1], wc[1], done_cyc, w1);
      end
    end
    checks++;
    if (done_cnt !== 1 || word_cnt !== 11'd2) begin
      failures++;
      $display("FAIL coinc_done dones=%0d cnt=%0d required 1 2",
               done_cnt, word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_rst_flush();
    test_back_to_back_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning encoded-word buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports start  input  1, base_addr  input  ADDR_W, end_req  input  1: session start pulse, first write address, end-of-program pulse.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1: source handshake for one instruction.
REQ-007 SHALL have ports in_opcode  input  2, in_func  input  4, in_rs  input  5, in_rt  input  5, in_imm  input  16: instruction fields.
REQ-008 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  32, mem_ready  input  1: instruction-memory write port.
REQ-009 SHALL have ports done  output  1, busy  output  1, wrap_err  output  1, illegal  output  1, word_cnt  output  ADDR_W+1.

Function
REQ-010 SHALL encode mem_wdata as [31:30]=opcode, [29:25]=rs, [24:20]=rt, [19:4]=imm, [3:0]=func.
REQ-011 SHALL implement FSM IDLE, LOAD, FLUSH, DONE; busy=1 in LOAD and FLUSH only.
REQ-012 IDLE: start=1 -> LOAD, write address register <= base_addr, word_cnt <= 0, wrap_err and illegal cleared.
REQ-013 LOAD: in_ready = not FIFO full; transfer occurs when in_valid and in_ready both 1; encoded word enqueued same edge.
REQ-014 LOAD: end_req=1 -> FLUSH; a transfer in the same cycle as end_req SHALL still be enqueued.
REQ-015 FLUSH: in_ready=0; when FIFO empty and no write pending -> DONE.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE; start ignored in LOAD, FLUSH, DONE.
REQ-017 mem_we SHALL be 1 whenever FIFO non-empty and state is LOAD or FLUSH; mem_wdata is FIFO head; write completes on edge with mem_we and mem_ready both 1.
REQ-018 Latency: word accepted at edge N SHALL appear on mem_we/mem_wdata from cycle after edge N (earliest write completes edge N+1).
REQ-019 Each completed write SHALL increment mem_addr (mod 2^ADDR_W) and word_cnt.
REQ-020 Write completing at address 2^ADDR_W-1 SHALL wrap mem_addr to 0 and set wrap_err sticky until next start or rst.
REQ-021 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged; when full, in_ready=0 even if a dequeue occurs that cycle.
REQ-022 mem_wdata and mem_addr SHALL hold stable while mem_we=1 and mem_ready=0.
REQ-023 in_valid in IDLE or DONE SHALL be ignored (in_ready=0).

Reset
REQ-024 rst=1 SHALL force IDLE, empty FIFO, mem_addr=0, word_cnt=0, mem_we=0, in_ready=0, done=0, busy=0, wrap_err=0, illegal=0.
REQ-025 rst mid-session SHALL discard buffered words; no write SHALL occur in the cycle after rst deasserts.

Configuration
REQ-026 Macro ILLEGAL_ENCODING_CHECK_EN defined: legal set is opcode 0 with func 0-7,10-15 and opcode 3 with func 0-7,9-12; illegal transfer SHALL be accepted (handshake completes), not enqueued, and illegal set sticky until start or rst.
REQ-027 Macro undefined: every transfer SHALL be enqueued unchanged; illegal SHALL be constant 0.

Verification
REQ-028 start, base_addr=0x010, three ADD words (op0,func0) back-to-back, mem_ready=1, end_req -> writes at 0x010,0x011,0x012, word_cnt=3, done one cycle.
REQ-029 mem_ready=0 for 10 cycles, 6 valid inputs -> in_ready falls after 4 accepted, mem_wdata stable; release -> 6 words written in order.
REQ-030 base_addr=0x3FE, 3 words -> addresses 0x3FE,0x3FF,0x000, wrap_err=1.
REQ-031 With ILLEGAL_ENCODING_CHECK_EN: op3 func8 between two legal words -> 2 writes, illegal=1, word_cnt=2; without macro -> 3 writes, illegal=0.
REQ-032 rst asserted in FLUSH with 3 words buffered -> next cycle IDLE, mem_we=0, word_cnt=0, no further writes.
REQ-033 end_req coincident with final transfer -> that word written before done; done pulses exactly once.
